pipe_stage_skid: RTL

//   Elastic pipeline stage register for the inter-stage boundaries of the pipelined

---
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage register for the core's inter-stage
// boundaries. A WIDTH-bit payload moves under a valid/ready handshake, with an
// optional second (skid) entry, a flush that turns the stage into a bubble, and
// a saturating counter of back-pressured cycles.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready).
// Once out_valid is high it stays high, and out_data stays unchanged, until
// out_fire or flush. in_valid may be raised regardless of in_ready.
//
// The FSM state encoding equals the number of held entries and is exported
// directly on occupancy, so the state is always observable.
module pipe_stage_skid #(
    parameter int               WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding is the entry count: EMPTY=0, ONE=1 (main full), TWO=2 (main+skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_ready_q;
    logic             main_valid;
    logic             in_fire;
    logic             out_fire;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign main_valid = (state != EMPTY);
    assign out_valid  = main_valid;
    assign out_data   = main_valid ? main_data : BUBBLE;
    assign occupancy  = state;

    // With a skid entry in_ready comes straight from a flop (no path from
    // out_ready); without one it must look at out_ready to keep full throughput.
    assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Entry-tracking FSM, payload registers, registered in_ready and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_data  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
            stall_cnt  <= '0;
        end else begin
            // The flush cycle is counted too: the stall was real until the edge.
            if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                // Held entries and any same-cycle input are dropped; a same-cycle
                // out_fire has already been taken downstream, so nothing to undo.
                state      <= EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_data <= in_data;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_data <= in_data;
                        end else if (in_fire) begin
                            // Only reachable with a skid entry: without one,
                            // in_ready in ONE implies out_ready, hence out_fire.
                            if (SKID != 0) begin
                                skid_data  <= in_data;
                                state      <= TWO;
                                in_ready_q <= 1'b0;
                            end
                        end else if (out_fire) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            main_data  <= skid_data;
                            state      <= ONE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= EMPTY;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
